// File: rtl/mkr_pin_event_capture.sv
// MKR header input capture: synchronise 23 pins, timestamp level changes,
// and queue {pin, level, time} events in a first-word-fall-through FIFO.
module mkr_pin_event_capture #(
    parameter int PIN_COUNT   = 23,
    parameter int TS_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PIN_COUNT-1:0] pin_mask,
    input  logic                 bMKR_AREF,
    input  logic [6:0]           bMKR_A,
    input  logic [14:0]          bMKR_D,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [4:0]           evt_pin,
    output logic                 evt_level,
    output logic [TS_WIDTH-1:0]  evt_time,
    output logic [3:0]           fifo_level,
    output logic [7:0]           overflow_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PCW = $clog2(SYNC_STAGES + 2);
    localparam int EW  = 5 + 1 + TS_WIDTH;

    logic [PIN_COUNT-1:0] pins;
    logic [PIN_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [PIN_COUNT-1:0] sync_w;
    logic [PIN_COUNT-1:0] prev_q;
    logic [PIN_COUNT-1:0] pending_q, pending_d;
    logic [PIN_COUNT-1:0] lvl_q;
    logic [PIN_COUNT-1:0] edge_v, accept, drop, clr;
    logic [TS_WIDTH-1:0]  ts_q [PIN_COUNT];
    logic [TS_WIDTH-1:0]  cnt_q;
    logic [PCW-1:0]       prime_q;
    logic                 primed;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic [AW-1:0]        wr_q, rd_q;
    logic [3:0]           level_q, level_d;
    logic [7:0]           ovf_q, ovf_d;
    logic [7:0]           drop_n;
    logic [8:0]           ovf_sum;
    logic [4:0]           sel;
    logic                 push, pop;

    assign pins   = {bMKR_D, bMKR_A, bMKR_AREF};
    assign sync_w = sync_q[SYNC_STAGES-1];

    // Edge detection stays off until the synchroniser has flushed its reset zeros,
    // so a pin held high through reset never looks like a rising edge.
    assign primed = (prime_q == PCW'(SYNC_STAGES + 1));
    assign edge_v = (sync_w ^ prev_q) & pin_mask & {PIN_COUNT{enable & primed}};

    assign evt_valid = (level_q != 4'd0);
    assign pop       = evt_valid & evt_ready;
    assign push      = (|pending_q) && (level_q < 4'(FIFO_DEPTH));

    always_comb begin
        sel = '0;
        for (int i = PIN_COUNT - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = 5'(i);
        end
    end

    always_comb begin
        clr = '0;
        if (push) clr[sel] = 1'b1;
    end

    // A pin whose pending bit is being dispatched this cycle may take a fresh edge.
    assign accept    = edge_v & (~pending_q | clr);
    assign drop      = edge_v & pending_q & ~clr;
    assign pending_d = (pending_q & ~clr) | accept;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < PIN_COUNT; i++) begin
            drop_n = drop_n + 8'(drop[i]);
        end
    end

    assign ovf_sum = {1'b0, ovf_q} + {1'b0, drop_n};
    assign ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    assign level_d = level_q + {3'b000, push} - {3'b000, pop};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < PIN_COUNT; i++) ts_q[i] <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            lvl_q     <= '0;
            cnt_q     <= '0;
            prime_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            ovf_q     <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q    <= sync_w;
            cnt_q     <= cnt_q + TS_WIDTH'(1);
            if (!primed) prime_q <= prime_q + PCW'(1);
            pending_q <= pending_d;
            for (int i = 0; i < PIN_COUNT; i++) begin
                if (accept[i]) begin
                    ts_q[i]  <= cnt_q;
                    lvl_q[i] <= sync_w[i];
                end
            end
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= {sel, lvl_q[sel], ts_q[sel]};
    end

    assign head           = mem_q[rd_q];
    assign evt_pin        = evt_valid ? head[EW-1 -: 5] : 5'd0;
    assign evt_level      = evt_valid & head[TS_WIDTH];
    assign evt_time       = evt_valid ? head[TS_WIDTH-1:0] : '0;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_mkr_pin_event_capture.sv
// Bench for mkr_pin_event_capture: vector table, hand sequences for
// latency/backpressure/drop/reset, and a randomized per-pin scoreboard.
module tb_mkr_pin_event_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [22:0] pin_mask;
    logic [22:0] pins;
    logic        bMKR_AREF;
    logic [6:0]  bMKR_A;
    logic [14:0] bMKR_D;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_pin;
    logic        evt_level;
    logic [31:0] evt_time;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_count;

    assign {bMKR_D, bMKR_A, bMKR_AREF} = pins;

    mkr_pin_event_capture dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .pin_mask       (pin_mask),
        .bMKR_AREF      (bMKR_AREF),
        .bMKR_A         (bMKR_A),
        .bMKR_D         (bMKR_D),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_pin        (evt_pin),
        .evt_level      (evt_level),
        .evt_time       (evt_time),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count)
    );

    always #10 clock = ~clock;

    // Clocks since reset release; equals the DUT timestamp counter.
    int cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        int port;
        int bitn;
        bit mask_off;
        bit en;
        bit exp_v;
        int exp_pin;
        bit exp_lvl;
    } vec_t;

    typedef struct {
        int   pin;
        logic lvl;
        int   t;
    } ev_t;

    vec_t tv [10];
    ev_t  exp_q [$];
    int   last [23];
    int   n_got;
    int   got_pin [40];
    logic got_lvl [40];
    int   got_time [40];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic toggle(input int p);
        pins[p] = ~pins[p];
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
    endtask

    task automatic drain(input int budget);
        n_got     = 0;
        evt_ready = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (evt_valid && n_got < 40) begin
                got_pin[n_got]  = int'(evt_pin);
                got_lvl[n_got]  = evt_level;
                got_time[n_got] = int'(evt_time);
                n_got++;
            end
            step(1);
        end
        evt_ready = 1'b0;
    endtask

    task automatic sb_pop();
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].pin == int'(evt_pin)) idx = i;
        end
        chk("rnd_match", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
            chk("rnd_level", 64'(evt_level), 64'(exp_q[idx].lvl));
            chk("rnd_time", 64'(evt_time), 64'(exp_q[idx].t));
            exp_q.delete(idx);
        end
    endtask

    function automatic int flat(input int port, input int b);
        return (port == 0) ? 0 : (port == 1) ? 1 + b : 8 + b;
    endfunction

    initial begin
        int   p, c, c1;
        logic l1;
        ev_t  e;

        // port: 0=AREF 1=A 2=D
        tv[0] = '{0, 0,  1'b0, 1'b1, 1'b1, 0,  1'b0};
        tv[1] = '{1, 0,  1'b0, 1'b1, 1'b1, 1,  1'b1};
        tv[2] = '{1, 6,  1'b0, 1'b1, 1'b1, 7,  1'b0};
        tv[3] = '{2, 14, 1'b0, 1'b1, 1'b1, 22, 1'b1};
        tv[4] = '{2, 7,  1'b0, 1'b1, 1'b1, 15, 1'b1};
        tv[5] = '{0, 0,  1'b0, 1'b1, 1'b1, 0,  1'b1};
        tv[6] = '{2, 0,  1'b1, 1'b1, 1'b0, 0,  1'b0};
        tv[7] = '{2, 0,  1'b0, 1'b0, 1'b0, 0,  1'b0};
        tv[8] = '{2, 14, 1'b0, 1'b1, 1'b1, 22, 1'b0};
        tv[9] = '{2, 5,  1'b0, 1'b1, 1'b1, 13, 1'b0};
        for (int i = 0; i < 23; i++) last[i] = -1000;

        reset     = 1'b1;
        enable    = 1'b1;
        evt_ready = 1'b0;
        pin_mask  = '1;
        pins      = '0;
        pins[13]  = 1'b1;
        step(3);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_pin", 64'(evt_pin), 64'd0);
        chk("rst_time", 64'(evt_time), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf", 64'(overflow_count), 64'd0);
        reset = 1'b0;

        // Pin 13 high through reset: nothing may appear.
        step(10);
        chk("prime_no_event", 64'(evt_valid), 64'd0);

        // First rising edge on D[0]: latency and timestamp.
        c = cyc;
        toggle(8);
        step(3);
        chk("lat_early", 64'(evt_valid), 64'd0);
        step(1);
        chk("lat_valid", 64'(evt_valid), 64'd1);
        chk("first_pin", 64'(evt_pin), 64'd8);
        chk("first_lvl", 64'(evt_level), 64'd1);
        chk("first_time", 64'(evt_time), 64'd12);
        pop_one();

        // AREF and A[6] together: same timestamp, consecutive pushes.
        c = cyc;
        toggle(0);
        toggle(7);
        step(4);
        chk("pair_lvl1", 64'(fifo_level), 64'd1);
        chk("pair_pin0", 64'(evt_pin), 64'd0);
        chk("pair_t0", 64'(evt_time), 64'(c + 2));
        step(1);
        chk("pair_lvl2", 64'(fifo_level), 64'd2);
        pop_one();
        chk("pair_pin7", 64'(evt_pin), 64'd7);
        chk("pair_t7", 64'(evt_time), 64'(c + 2));
        chk("pair_l7", 64'(evt_level), 64'd1);
        pop_one();
        chk("pair_empty", 64'(fifo_level), 64'd0);

        for (int i = 0; i < 10; i++) begin
            p        = flat(tv[i].port, tv[i].bitn);
            pin_mask = '1;
            if (tv[i].mask_off) pin_mask[p] = 1'b0;
            enable = tv[i].en;
            c      = cyc;
            toggle(p);
            step(6);
            chk($sformatf("vec%0d_valid", i), 64'(evt_valid), 64'(tv[i].exp_v));
            if (tv[i].exp_v) begin
                chk($sformatf("vec%0d_pin", i), 64'(evt_pin), 64'(tv[i].exp_pin));
                chk($sformatf("vec%0d_lvl", i), 64'(evt_level), 64'(tv[i].exp_lvl));
                chk($sformatf("vec%0d_time", i), 64'(evt_time), 64'(c + 2));
                pop_one();
            end
            pin_mask = '1;
            enable   = 1'b1;
            step(2);
            chk($sformatf("vec%0d_after", i), 64'(evt_valid), 64'd0);
        end

        // Backpressure: 9 pins, FIFO holds 8, one stays pending.
        for (int q = 1; q <= 9; q++) toggle(q);
        step(20);
        chk("bp_full", 64'(fifo_level), 64'd8);
        chk("bp_head", 64'(evt_pin), 64'd1);
        drain(30);
        chk("bp_count", 64'(n_got), 64'd9);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("bp_pin%0d", j), 64'(got_pin[j]), 64'(j + 1));
            chk($sformatf("bp_lvl%0d", j), 64'(got_lvl[j]), 64'(pins[j+1]));
        end
        chk("bp_ovf", 64'(overflow_count), 64'd0);

        // Drop: FIFO full, D[3] toggles twice while pending.
        for (int q = 12; q <= 19; q++) toggle(q);
        step(16);
        chk("drop_full", 64'(fifo_level), 64'd8);
        c1 = cyc;
        toggle(11);
        l1 = pins[11];
        step(5);
        toggle(11);
        step(5);
        chk("drop_ovf", 64'(overflow_count), 64'd1);
        chk("drop_still_full", 64'(fifo_level), 64'd8);
        drain(30);
        chk("drop_count", 64'(n_got), 64'd9);
        chk("drop_first", 64'(got_pin[0]), 64'd12);
        chk("drop_pin", 64'(got_pin[8]), 64'd11);
        chk("drop_lvl", 64'(got_lvl[8]), 64'(l1));
        chk("drop_time", 64'(got_time[8]), 64'(c1 + 2));
        chk("drop_empty", 64'(fifo_level), 64'd0);

        // Reset with 5 events queued.
        for (int q = 1; q <= 5; q++) toggle(q);
        step(10);
        chk("mid_queued", 64'(fifo_level), 64'd5);
        reset = 1'b1;
        #1;
        chk("mid_valid", 64'(evt_valid), 64'd0);
        chk("mid_level", 64'(fifo_level), 64'd0);
        chk("mid_ovf", 64'(overflow_count), 64'd0);
        chk("mid_time", 64'(evt_time), 64'd0);
        step(2);
        reset = 1'b0;
        step(8);
        chk("mid_no_event", 64'(evt_valid), 64'd0);
        toggle(20);
        step(6);
        chk("mid_restart_v", 64'(evt_valid), 64'd1);
        chk("mid_restart_pin", 64'(evt_pin), 64'd20);
        chk("mid_restart_t", 64'(evt_time), 64'd10);
        pop_one();

        // Random toggles, per-pin gap wide enough that nothing is ever dropped.
        for (int k = 0; k < 3000; k++) begin
            evt_ready = 1'($urandom_range(0, 1));
            if (evt_valid && evt_ready) sb_pop();
            if ($urandom_range(0, 3) == 0) begin
                p = int'($urandom_range(0, 22));
                if (cyc - last[p] >= 80) begin
                    toggle(p);
                    e.pin = p;
                    e.lvl = pins[p];
                    e.t   = cyc + 2;
                    exp_q.push_back(e);
                    last[p] = cyc;
                end
            end
            step(1);
        end
        evt_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (evt_valid) sb_pop();
            step(1);
        end
        evt_ready = 1'b0;
        chk("rnd_left", 64'(exp_q.size()), 64'd0);
        chk("rnd_ovf", 64'(overflow_count), 64'd0);
        chk("rnd_empty", 64'(fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
